// File: rtl/reg_context_engine.sv
// Context save/restore engine: spills the 32x8 register file to memory as 16-bit pairs and refills it.
// Optional trailing XOR checksum word and ctx_err flag are enabled by defining REG_CTX_CHECKSUM_EN.
module reg_context_engine #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              save_req,
  input  logic              restore_req,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              ctx_err,
  output logic [1:0]        rf_rd_en,
  output logic [9:0]        rf_rd_addr,
  input  logic [15:0]       rf_data_out,
  output logic [1:0]        rf_wr_en,
  output logic [9:0]        rf_wr_addr,
  output logic [15:0]       rf_data_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned P_W   = 5;
  localparam int unsigned PAIRS = NUM_REGS / 2;
  localparam logic [P_W-1:0] LAST_P = P_W'(PAIRS - 1);
`ifdef REG_CTX_CHECKSUM_EN
  localparam logic [P_W-1:0] CK_P = P_W'(PAIRS);
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SAVE_RD  = 3'd1,
    SAVE_MEM = 3'd2,
    RST_MEM  = 3'd3,
    RST_WR   = 3'd4,
    DONE     = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [P_W-1:0]    p_q, p_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        rf_rd_en_q, rf_rd_en_d;
  logic [9:0]        rf_rd_addr_q, rf_rd_addr_d;
  logic [1:0]        rf_wr_en_q, rf_wr_en_d;
  logic [9:0]        rf_wr_addr_q, rf_wr_addr_d;
  logic [15:0]       rf_data_in_q, rf_data_in_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic [4:0]        even_a;
  logic [9:0]        pair_a;
`ifdef REG_CTX_CHECKSUM_EN
  logic [15:0]       csum_q, csum_d;
  logic              err_q, err_d;
`endif

  // Next state plus registered port values decoded from the state being entered
  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    base_d       = base_q;
    mem_wdata_d  = mem_wdata_q;
    rf_data_in_d = rf_data_in_q;
`ifdef REG_CTX_CHECKSUM_EN
    csum_d       = csum_q;
    err_d        = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (save_req || restore_req) begin
          state_d = save_req ? SAVE_RD : RST_MEM;
          base_d  = base_addr;
          p_d     = '0;
`ifdef REG_CTX_CHECKSUM_EN
          csum_d  = '0;
          err_d   = 1'b0;
`endif
        end
      end
      SAVE_RD: begin
        mem_wdata_d = rf_data_out;
        state_d     = SAVE_MEM;
      end
      SAVE_MEM: begin
        if (mem_ack) begin
`ifdef REG_CTX_CHECKSUM_EN
          if (p_q == CK_P) begin
            state_d = DONE;
          end else begin
            csum_d = csum_q ^ mem_wdata_q;
            p_d    = p_q + P_W'(1);
            if (p_q == LAST_P) begin
              mem_wdata_d = csum_q ^ mem_wdata_q;
            end else begin
              state_d = SAVE_RD;
            end
          end
`else
          if (p_q == LAST_P) begin
            state_d = DONE;
          end else begin
            p_d     = p_q + P_W'(1);
            state_d = SAVE_RD;
          end
`endif
        end
      end
      RST_MEM: begin
        if (mem_ack) begin
`ifdef REG_CTX_CHECKSUM_EN
          if (p_q == CK_P) begin
            err_d   = (mem_rdata != csum_q);
            state_d = DONE;
          end else begin
            csum_d       = csum_q ^ mem_rdata;
            rf_data_in_d = mem_rdata;
            state_d      = RST_WR;
          end
`else
          rf_data_in_d = mem_rdata;
          state_d      = RST_WR;
`endif
        end
      end
      RST_WR: begin
`ifdef REG_CTX_CHECKSUM_EN
        p_d     = p_q + P_W'(1);
        state_d = RST_MEM;
`else
        if (p_q == LAST_P) begin
          state_d = DONE;
        end else begin
          p_d     = p_q + P_W'(1);
          state_d = RST_MEM;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    even_a       = {p_d[3:0], 1'b0};
    pair_a       = {even_a | 5'd1, even_a};
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
    rf_rd_en_d   = (state_d == SAVE_RD) ? 2'b11 : 2'b00;
    rf_rd_addr_d = (state_d == SAVE_RD) ? pair_a : 10'd0;
    rf_wr_en_d   = (state_d == RST_WR) ? 2'b11 : 2'b00;
    rf_wr_addr_d = (state_d == RST_WR) ? pair_a : 10'd0;
    mem_req_d    = (state_d == SAVE_MEM) || (state_d == RST_MEM);
    mem_we_d     = (state_d == SAVE_MEM);
    mem_addr_d   = mem_req_d ? (base_d + ADDR_W'(p_d)) : '0;
    if (state_d != SAVE_MEM) mem_wdata_d  = '0;
    if (state_d != RST_WR)   rf_data_in_d = '0;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      p_q          <= '0;
      base_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rf_rd_en_q   <= '0;
      rf_rd_addr_q <= '0;
      rf_wr_en_q   <= '0;
      rf_wr_addr_q <= '0;
      rf_data_in_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
`ifdef REG_CTX_CHECKSUM_EN
      csum_q       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      base_q       <= base_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_rd_addr_q <= rf_rd_addr_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_data_in_q <= rf_data_in_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
`ifdef REG_CTX_CHECKSUM_EN
      csum_q       <= csum_d;
      err_q        <= err_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rf_rd_en   = rf_rd_en_q;
  assign rf_rd_addr = rf_rd_addr_q;
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_data_in = rf_data_in_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
`ifdef REG_CTX_CHECKSUM_EN
  assign ctx_err    = err_q;
`else
  assign ctx_err    = 1'b0;
`endif

endmodule

// File: tb/tb_reg_context_engine.sv
// Bench for reg_context_engine: register-file and memory models, a transaction scoreboard and directed scenarios.
module tb_reg_context_engine;
  localparam int P = 16;
`ifdef REG_CTX_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        save_req = 1'b0, restore_req = 1'b0;
  logic [15:0] base_addr = 16'h0;
  logic        busy, done, ctx_err;
  logic [1:0]  rf_rd_en, rf_wr_en;
  logic [9:0]  rf_rd_addr, rf_wr_addr;
  logic [15:0] rf_data_out, rf_data_in;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clock = ~clock;

  reg_context_engine #(.NUM_REGS(32), .ADDR_W(16)) dut (
    .clock(clock), .nreset(nreset), .save_req(save_req), .restore_req(restore_req),
    .base_addr(base_addr), .busy(busy), .done(done), .ctx_err(ctx_err),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_data_out(rf_data_out),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_data_in(rf_data_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Register file and memory models
  logic [7:0]  rf [0:31];
  logic [15:0] mem [0:65535];
  int          wait_cfg = 0;
  int          wcnt = 0;

  assign rf_data_out = {rf[rf_rd_addr[9:5]], rf[rf_rd_addr[4:0]]};
  assign mem_ack     = mem_req && (wcnt == wait_cfg);
  assign mem_rdata   = mem_ack ? mem[mem_addr] : 16'h0;

  always @(negedge clock)
    if (rf_wr_en == 2'b11) begin
      rf[rf_wr_addr[4:0]] = rf_data_in[7:0];
      rf[rf_wr_addr[9:5]] = rf_data_in[15:8];
    end

  always @(posedge clock) begin
    if (mem_req && mem_ack && mem_we) mem[mem_addr] = mem_wdata;
    if (mem_req && !mem_ack) wcnt = wcnt + 1;
    else wcnt = 0;
  end

  typedef struct packed { logic we; logic [15:0] addr; logic [15:0] data; } mtx_t;
  typedef struct packed { logic [9:0] addr; logic [15:0] data; } rtx_t;
  mtx_t exp_m[$];
  rtx_t exp_r[$];

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle checker: port protocol plus in-order transaction scoreboard
  logic        prev_pend = 1'b0, prev_wr = 1'b0;
  logic [32:0] prev_m = '0;
  always @(negedge clock) begin
    if (!nreset) begin
      prev_pend = 1'b0;
      prev_wr   = 1'b0;
    end else begin
      mtx_t em;
      rtx_t er;
      chk("rd_en_whole", 64'(rf_rd_en == 2'b00 || rf_rd_en == 2'b11), 64'd1);
      if (!busy)
        chk("idle_ports", 64'({rf_rd_en, rf_wr_en, mem_req, mem_we, |rf_rd_addr, |rf_wr_addr,
                                |rf_data_in, |mem_addr, |mem_wdata}), 64'd0);
      else if (!mem_req)
        chk("mem_quiet", 64'({mem_we, |mem_addr, |mem_wdata}), 64'd0);
      if (prev_pend) chk("mem_stable", 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'({1'b1, prev_m}));
      if (prev_wr) chk("wr_pulse_width", 64'(rf_wr_en), 64'd0);
      if (mem_req && mem_ack) begin
        if (exp_m.size() == 0) chk("mem_extra_tx", 64'({mem_we, mem_addr}), 64'h1_FFFF_FFFF);
        else begin
          em = exp_m.pop_front();
          chk("mem_tx", 64'({mem_we, mem_addr, mem_wdata}), 64'(em));
        end
      end
      if (rf_wr_en != 2'b00) begin
        if (exp_r.size() == 0) chk("rf_extra_wr", 64'(rf_wr_addr), 64'h3FF_FFFF);
        else begin
          er = exp_r.pop_front();
          chk("rf_wr", 64'({rf_wr_en, rf_wr_addr, rf_data_in}), 64'({2'b11, er}));
        end
      end
      if (done) done_cnt++;
      prev_pend = mem_req && !mem_ack;
      prev_m    = {mem_we, mem_addr, mem_wdata};
      prev_wr   = (rf_wr_en != 2'b00);
    end
  end

  // Expected transfers: save wins over restore; word base+p = {reg 2p+1, reg 2p}
  task automatic build_exp(input bit sv, input bit rs, input logic [15:0] base);
    logic [15:0] x, w, a;
    x = 16'h0;
    for (int p = 0; p < P; p++) begin
      a = base + 16'(p);
      if (sv) begin
        w = {rf[2*p+1], rf[2*p]};
        exp_m.push_back({1'b1, a, w});
      end else if (rs) begin
        w = mem[a];
        exp_m.push_back({1'b0, a, 16'h0});
        exp_r.push_back({5'(2*p+1), 5'(2*p), w});
      end
      x = x ^ w;
    end
    if (CK == 1 && sv) exp_m.push_back({1'b1, base + 16'(P), x});
    if (CK == 1 && !sv && rs) exp_m.push_back({1'b0, base + 16'(P), 16'h0});
  endtask

  task automatic issue(input bit sv, input bit rs, input logic [15:0] base);
    @(negedge clock);
    save_req = sv; restore_req = rs; base_addr = base;
    @(posedge clock);
    #1;
    save_req = 1'b0; restore_req = 1'b0; base_addr = 16'hDEAD;
  endtask

  task automatic run_op(input string name, input bit sv, input bit rs, input logic [15:0] base,
                        input int w, input int pulse_at, input bit exp_err);
    int cyc;
    int exp_cyc;
    wait_cfg = w;
    done_cnt = 0;
    build_exp(sv, rs, base);
    exp_cyc = P * (2 + w) + 1 + CK * (1 + w);
    issue(sv, rs, base);
    cyc = 0;
    while (1) begin
      @(negedge clock);
      cyc++;
      save_req = (cyc == pulse_at);
      if (done) break;
      if (cyc > 2000) begin
        chk({name, "_timeout"}, 64'(cyc), 64'(exp_cyc));
        break;
      end
    end
    save_req = 1'b0;
    chk({name, "_latency"}, 64'(cyc), 64'(exp_cyc));
    chk({name, "_ctx_err"}, 64'(ctx_err), 64'(exp_err));
    @(negedge clock);
    chk({name, "_busy_after"}, 64'(busy), 64'd0);
    chk({name, "_done_once"}, 64'(done_cnt), 64'd1);
    @(negedge clock);
    chk({name, "_no_requeue"}, 64'(busy), 64'd0);
    chk({name, "_mem_left"}, 64'(exp_m.size()), 64'd0);
    chk({name, "_rf_left"}, 64'(exp_r.size()), 64'd0);
    exp_m.delete();
    exp_r.delete();
  endtask

  initial begin
    logic [15:0] x;
    int k;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    for (int i = 0; i < 32; i++) rf[i] = 8'hA0 + 8'(i);

    repeat (2) @(negedge clock);
    chk("reset_outputs", 64'({busy, done, ctx_err, rf_rd_en, rf_wr_en, mem_req, mem_we}), 64'd0);
    chk("reset_addrs", 64'({rf_rd_addr, rf_wr_addr, mem_addr}), 64'd0);
    chk("reset_data", 64'({rf_data_in, mem_wdata}), 64'd0);
    #2 nreset = 1'b1;
    @(negedge clock);

    // Save with zero-wait memory
    run_op("save0", 1'b1, 1'b0, 16'h0100, 0, -1, 1'b0);
    chk("save0_w0", 64'(mem[16'h0100]), 64'hA1A0);
    chk("save0_w7", 64'(mem[16'h0107]), 64'hAFAE);
    chk("save0_w15", 64'(mem[16'h010F]), 64'hBFBE);

    // Restore with 3 wait states
    x = 16'h0;
    for (int i = 0; i < P; i++) begin
      mem[16'h0200 + 16'(i)] = 16'(16'h1111 * i);
      x = x ^ 16'(16'h1111 * i);
    end
    mem[16'h0210] = x;
    run_op("rest3", 1'b0, 1'b1, 16'h0200, 3, -1, 1'b0);
    chk("rest3_r0", 64'(rf[0]), 64'h00);
    chk("rest3_r3", 64'(rf[3]), 64'h11);
    chk("rest3_r20", 64'(rf[20]), 64'hAA);
    chk("rest3_r31", 64'(rf[31]), 64'hFF);

    // Both requests together, plus a save_req pulse mid-operation
    run_op("contend", 1'b1, 1'b1, 16'h0500, 0, 10, 1'b0);
    chk("contend_w5", 64'(mem[16'h0505]), 64'h5555);

    // Address wrap-around
    run_op("wrap", 1'b1, 1'b0, 16'hFFF8, 1, -1, 1'b0);
    chk("wrap_fff8", 64'(mem[16'hFFF8]), 64'h0000);
    chk("wrap_ffff", 64'(mem[16'hFFFF]), 64'h7777);
    chk("wrap_0000", 64'(mem[16'h0000]), 64'h8888);
    chk("wrap_0007", 64'(mem[16'h0007]), 64'hFFFF);

    // Reset while SAVE_MEM at pair 5 is waiting for ack
    wait_cfg = 2;
    build_exp(1'b1, 1'b0, 16'h0400);
    issue(1'b1, 1'b0, 16'h0400);
    k = 0;
    while (!(mem_req && mem_addr == 16'h0405) && k < 300) begin
      @(negedge clock);
      k++;
    end
    chk("rst_reached_pair5", 64'(mem_req && mem_addr == 16'h0405), 64'd1);
    #1 nreset = 1'b0;
    #1;
    chk("rst_async_drop", 64'({mem_req, busy, mem_we, rf_rd_en}), 64'd0);
    exp_m.delete();
    exp_r.delete();
    @(negedge clock);
    #2 nreset = 1'b1;
    run_op("after_rst", 1'b1, 1'b0, 16'h0400, 0, -1, 1'b0);
    chk("after_rst_w0", 64'(mem[16'h0400]), 64'h0000);

`ifdef REG_CTX_CHECKSUM_EN
    for (int i = 0; i < 32; i++) rf[i] = 8'h3C ^ 8'(7 * i);
    run_op("ck_save", 1'b1, 1'b0, 16'h0300, 1, -1, 1'b0);
    run_op("ck_rest", 1'b0, 1'b1, 16'h0300, 0, -1, 1'b0);
    mem[16'h0305] = mem[16'h0305] ^ 16'h0010;
    run_op("ck_bad", 1'b0, 1'b1, 16'h0300, 2, -1, 1'b1);
    chk("ck_err_held", 64'(ctx_err), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
